// File: rtl/digest_tx_serializer_pkg.sv
// rtl/digest_tx_serializer_pkg.sv - shared types, constants and width helpers for the digest serializer
//
// Contents:
//   state_e           FSM state encoding (IDLE, LOAD, ISSUE, WAIT, DONE)
//   DIGEST_*          default digest geometry (256-bit digest, 8 words, byte chunks)
//   calc_total()      frame buffer width in bits
//   calc_chunks()     number of OUT_WIDTH chunks per frame
package digest_tx_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int DIGEST_BITS       = 256;
  localparam int DIGEST_WORDS      = 8;
  localparam int DIGEST_CHUNK_BITS = 8;

  function automatic int calc_total(input int num_words, input int data_width);
    return num_words * data_width;
  endfunction

  function automatic int calc_chunks(input int num_words, input int data_width,
                                     input int out_width);
    return (num_words * data_width) / out_width;
  endfunction

endpackage

// File: rtl/digest_tx_serializer_if.sv
// rtl/digest_tx_serializer_if.sv - core-side and UART-side handshake bundle for the digest serializer
//
// Signals:
//   core_word_in / core_valid_in / core_ready_out   word stream from the hash core
//   TX_active_in / TX_done_in                       UART transmitter status
//   MP_data_out / MP_dv_out                         chunk and start pulse to the transmitter
//   busy_out / frame_done_out                       frame status
// Modports:
//   slave   serializer view
//   master  driver (core + transmitter) view
interface digest_tx_serializer_if
  import digest_tx_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DIGEST_BITS / DIGEST_WORDS,
  parameter int OUT_WIDTH  = DIGEST_CHUNK_BITS
) ();

  logic [DATA_WIDTH-1:0] core_word_in;
  logic                  core_valid_in;
  logic                  core_ready_out;
  logic                  TX_active_in;
  logic                  TX_done_in;
  logic [OUT_WIDTH-1:0]  MP_data_out;
  logic                  MP_dv_out;
  logic                  busy_out;
  logic                  frame_done_out;

  modport slave (
    input  core_word_in, core_valid_in, TX_active_in, TX_done_in,
    output core_ready_out, MP_data_out, MP_dv_out, busy_out, frame_done_out
  );

  modport master (
    output core_word_in, core_valid_in, TX_active_in, TX_done_in,
    input  core_ready_out, MP_data_out, MP_dv_out, busy_out, frame_done_out
  );

endinterface

// File: rtl/digest_tx_serializer_rise_edge_det.sv
// rtl/digest_tx_serializer_rise_edge_det.sv - registered rising-edge detector
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset (previous sample cleared to 0)
//   sig_in    level or pulse input
//   rise_out  high while sig_in is 1 and was 0 at the previous rising clock edge
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise_out
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = sig_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_out = sig_in & ~prev_q;

endmodule

// File: rtl/digest_tx_serializer.sv
// rtl/digest_tx_serializer.sv - frame buffer that collects core words and streams them as chunks to the UART TX
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    digest_tx_serializer_if.slave: core word stream in, chunk/dv out to the
//          transmitter, TX_active/TX_done from the transmitter, busy and frame-done status
// Parameters:
//   DATA_WIDTH  core word width (multiple of OUT_WIDTH)
//   NUM_WORDS   words per frame
//   OUT_WIDTH   chunk width
//   LSB_FIRST   0 = most-significant chunk first, 1 = least-significant chunk first
module digest_tx_serializer
  import digest_tx_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DIGEST_BITS / DIGEST_WORDS,
  parameter int NUM_WORDS  = DIGEST_WORDS,
  parameter int OUT_WIDTH  = DIGEST_CHUNK_BITS,
  parameter int LSB_FIRST  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  digest_tx_serializer_if.slave  bus
);

  localparam int TOTAL  = calc_total(NUM_WORDS, DATA_WIDTH);
  localparam int CHUNKS = calc_chunks(NUM_WORDS, DATA_WIDTH, OUT_WIDTH);
  localparam int WCW    = $clog2(NUM_WORDS + 1);
  localparam int CCW    = $clog2(CHUNKS + 1);

  state_e               state_q, state_d;
  logic [TOTAL-1:0]     buf_q, buf_d;
  logic [WCW-1:0]       word_cnt_q, word_cnt_d;
  logic [CCW-1:0]       chunk_cnt_q, chunk_cnt_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 tx_edge;

  rise_edge_det u_tx_done_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (bus.TX_done_in),
    .rise_out (tx_edge)
  );

  // Chunk sent at count c; with LSB_FIRST the slice index runs backwards from the end.
  function automatic logic [OUT_WIDTH-1:0] chunk_sel(input logic [TOTAL-1:0] b,
                                                     input logic [CCW-1:0]   c);
    logic [CCW-1:0]       j;
    logic [OUT_WIDTH-1:0] r;
    j = (LSB_FIRST != 0) ? (CCW'(CHUNKS - 1) - c) : c;
    r = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (j == CCW'(i)) begin
        r = b[TOTAL-1-i*OUT_WIDTH -: OUT_WIDTH];
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    word_cnt_d  = word_cnt_q;
    chunk_cnt_d = chunk_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.core_valid_in) begin
          buf_d[TOTAL-1 -: DATA_WIDTH] = bus.core_word_in;
          word_cnt_d = WCW'(1);
          if (NUM_WORDS == 1) begin
            state_d     = ST_ISSUE;
            chunk_cnt_d = '0;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (bus.core_valid_in) begin
          // First arrival occupies the most significant word of the buffer.
          for (int k = 0; k < NUM_WORDS; k++) begin
            if (word_cnt_q == WCW'(k)) begin
              buf_d[TOTAL-1-k*DATA_WIDTH -: DATA_WIDTH] = bus.core_word_in;
            end
          end
          word_cnt_d = word_cnt_q + WCW'(1);
          if (word_cnt_q == WCW'(NUM_WORDS - 1)) begin
            state_d     = ST_ISSUE;
            chunk_cnt_d = '0;
          end
        end
      end

      ST_ISSUE: begin
        // The dv pulse is this cycle; any TX_done edge seen now belongs to nothing.
        if (!bus.TX_active_in) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (tx_edge) begin
          if (chunk_cnt_q == CCW'(CHUNKS - 1)) begin
            state_d = ST_DONE;
          end else begin
            chunk_cnt_d = chunk_cnt_q + CCW'(1);
            state_d     = ST_ISSUE;
          end
        end
      end

      ST_DONE: begin
        word_cnt_d = '0;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up with state_q.
    ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    if ((state_d == ST_ISSUE) || (state_d == ST_WAIT)) begin
      data_d = chunk_sel(buf_d, chunk_cnt_d);
    end else begin
      data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      word_cnt_q  <= '0;
      chunk_cnt_q <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      word_cnt_q  <= word_cnt_d;
      chunk_cnt_q <= chunk_cnt_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      data_q      <= data_d;
    end
  end

  assign bus.core_ready_out = ready_q;
  assign bus.busy_out       = busy_q;
  assign bus.frame_done_out = done_q;
  assign bus.MP_data_out    = data_q;
  // Start pulse is issued the first ISSUE cycle the transmitter is idle.
  assign bus.MP_dv_out      = (state_q == ST_ISSUE) && !bus.TX_active_in;

endmodule

// File: tb/tb_digest_tx_serializer.sv
// tb/tb_digest_tx_serializer.sv - directed self-checking bench for digest_tx_serializer
module tb_digest_tx_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] core_word;
  logic        core_valid, tx_active, tx_done;
  logic [63:0] c_word;
  logic        c_valid, c_active, c_done;

  digest_tx_serializer_if #(.DATA_WIDTH(32), .OUT_WIDTH(8))  if_a ();
  digest_tx_serializer_if #(.DATA_WIDTH(32), .OUT_WIDTH(8))  if_b ();
  digest_tx_serializer_if #(.DATA_WIDTH(64), .OUT_WIDTH(16)) if_c ();

  assign if_a.core_word_in  = core_word;
  assign if_a.core_valid_in = core_valid;
  assign if_a.TX_active_in  = tx_active;
  assign if_a.TX_done_in    = tx_done;
  assign if_b.core_word_in  = core_word;
  assign if_b.core_valid_in = core_valid;
  assign if_b.TX_active_in  = tx_active;
  assign if_b.TX_done_in    = tx_done;
  assign if_c.core_word_in  = c_word;
  assign if_c.core_valid_in = c_valid;
  assign if_c.TX_active_in  = c_active;
  assign if_c.TX_done_in    = c_done;

  digest_tx_serializer #(.DATA_WIDTH(32), .NUM_WORDS(8), .OUT_WIDTH(8), .LSB_FIRST(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  digest_tx_serializer #(.DATA_WIDTH(32), .NUM_WORDS(8), .OUT_WIDTH(8), .LSB_FIRST(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  digest_tx_serializer #(.DATA_WIDTH(64), .NUM_WORDS(4), .OUT_WIDTH(16), .LSB_FIRST(0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  int n_cmp = 0;
  int n_fail = 0;
  int dv_cnt_a = 0, done_cnt_a = 0, dv_cnt_c = 0, done_cnt_c = 0;

  always @(posedge clk) begin
    if (if_a.MP_dv_out)      dv_cnt_a   <= dv_cnt_a + 1;
    if (if_a.frame_done_out) done_cnt_a <= done_cnt_a + 1;
    if (if_c.MP_dv_out)      dv_cnt_c   <= dv_cnt_c + 1;
    if (if_c.frame_done_out) done_cnt_c <= done_cnt_c + 1;
  end

  logic [31:0] words [8];
  logic [7:0]  exp_a [32];
  logic [7:0]  exp_b [32];
  logic [63:0] c_words [4];
  logic [15:0] exp_c [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic load_ab();
    for (int i = 0; i < 8; i++) begin
      check("ready_load", 64'(if_a.core_ready_out), 64'd1);
      core_valid = 1'b1;
      core_word  = words[i];
      step();
    end
    core_valid = 1'b0;
  endtask

  task automatic wait_dv_ab();
    int t;
    t = 0;
    while (!if_a.MP_dv_out && t < 64) begin
      step();
      t++;
    end
    check("dv_seen", 64'(if_a.MP_dv_out), 64'd1);
  endtask

  task automatic serve_ab(input int first, input int last);
    for (int c = first; c <= last; c++) begin
      wait_dv_ab();
      check("chunk_a", 64'(if_a.MP_data_out), 64'(exp_a[c]));
      check("chunk_b", 64'(if_b.MP_data_out), 64'(exp_b[c]));
      check("dv_b", 64'(if_b.MP_dv_out), 64'd1);
      step();
      check("dv_width", 64'(if_a.MP_dv_out), 64'd0);
      check("chunk_hold", 64'(if_a.MP_data_out), 64'(exp_a[c]));
      step();
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
    end
  endtask

  task automatic finish_frame_ab(input int dv0, input int done0, input int exp_dv);
    check("frame_done_a", 64'(if_a.frame_done_out), 64'd1);
    check("frame_done_b", 64'(if_b.frame_done_out), 64'd1);
    step();
    check("done_width", 64'(if_a.frame_done_out), 64'd0);
    check("idle_busy", 64'(if_a.busy_out), 64'd0);
    check("idle_ready", 64'(if_a.core_ready_out), 64'd1);
    check("dv_count", 64'(dv_cnt_a - dv0), 64'(exp_dv));
    check("done_count", 64'(done_cnt_a - done0), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  dv0, done0, t;
    bit  any_dv;

    words = '{32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
              32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};
    for (int c = 0; c < 32; c++) begin
      exp_a[c] = 8'(words[c / 4] >> (24 - 8 * (c % 4)));
    end
    for (int c = 0; c < 32; c++) begin
      exp_b[c] = exp_a[31 - c];
    end
    c_words = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                64'h0011223344556677, 64'h8899AABBCCDDEEFF};
    exp_c = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'hFEDC, 16'hBA98, 16'h7654, 16'h3210,
              16'h0011, 16'h2233, 16'h4455, 16'h6677, 16'h8899, 16'hAABB, 16'hCCDD, 16'hEEFF};

    rst_n = 1'b0;
    core_word = '0; core_valid = 1'b0; tx_active = 1'b0; tx_done = 1'b0;
    c_word = '0; c_valid = 1'b0; c_active = 1'b0; c_done = 1'b0;
    step();
    step();
    check("rst_ready_a", 64'(if_a.core_ready_out), 64'd1);
    check("rst_busy_a", 64'(if_a.busy_out), 64'd0);
    check("rst_dv_a", 64'(if_a.MP_dv_out), 64'd0);
    check("rst_done_a", 64'(if_a.frame_done_out), 64'd0);
    check("rst_data_a", 64'(if_a.MP_data_out), 64'd0);
    check("rst_ready_c", 64'(if_c.core_ready_out), 64'd1);
    check("rst_data_c", 64'(if_c.MP_data_out), 64'd0);
    rst_n = 1'b1;
    step();

    // Test 1 + 2: default MSB-first (A) and LSB-first (B) full frame
    dv0 = dv_cnt_a; done0 = done_cnt_a;
    load_ab();
    check("latency_dv", 64'(if_a.MP_dv_out), 64'd1);
    check("busy_issue", 64'(if_a.busy_out), 64'd1);
    check("ready_issue", 64'(if_a.core_ready_out), 64'd0);
    check("first_chunk_a", 64'(if_a.MP_data_out), 64'h6A);
    check("first_chunk_b", 64'(if_b.MP_data_out), 64'h19);
    serve_ab(0, 31);
    finish_frame_ab(dv0, done0, 32);

    // Test 3: transmitter busy after last word, then TX_done held high
    dv0 = dv_cnt_a; done0 = done_cnt_a;
    tx_active = 1'b1;
    load_ab();
    any_dv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      any_dv = any_dv | if_a.MP_dv_out;
      step();
    end
    check("no_dv_while_active", 64'(any_dv), 64'd0);
    tx_active = 1'b0;
    #1;
    check("dv_after_active_fall", 64'(if_a.MP_dv_out), 64'd1);
    check("chunk0_after_active", 64'(if_a.MP_data_out), 64'h6A);
    step();
    tx_done = 1'b1;
    step();
    check("dv_chunk1_held", 64'(if_a.MP_dv_out), 64'd1);
    check("chunk1_held", 64'(if_a.MP_data_out), 64'h09);
    step(); step(); step(); step();
    tx_done = 1'b0;
    check("held_no_dv", 64'(if_a.MP_dv_out), 64'd0);
    check("held_chunk_stays", 64'(if_a.MP_data_out), 64'h09);
    check("held_dv_count", 64'(dv_cnt_a - dv0), 64'd2);
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    serve_ab(2, 31);
    finish_frame_ab(dv0, done0, 32);

    // Test 4: core word offered while sending is refused and not stored
    dv0 = dv_cnt_a; done0 = done_cnt_a;
    load_ab();
    wait_dv_ab();
    check("t4_chunk0", 64'(if_a.MP_data_out), 64'h6A);
    step();
    core_valid = 1'b1;
    core_word  = 32'hDEADBEEF;
    check("ready_in_wait", 64'(if_a.core_ready_out), 64'd0);
    step();
    step();
    check("ready_in_wait2", 64'(if_a.core_ready_out), 64'd0);
    core_valid = 1'b0;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    serve_ab(1, 31);
    finish_frame_ab(dv0, done0, 32);

    // Test 5: asynchronous reset mid-frame at chunk 12
    load_ab();
    serve_ab(0, 11);
    wait_dv_ab();
    check("t5_chunk12", 64'(if_a.MP_data_out), 64'(exp_a[12]));
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data_a", 64'(if_a.MP_data_out), 64'd0);
    check("arst_data_b", 64'(if_b.MP_data_out), 64'd0);
    check("arst_busy", 64'(if_a.busy_out), 64'd0);
    check("arst_dv", 64'(if_a.MP_dv_out), 64'd0);
    check("arst_done", 64'(if_a.frame_done_out), 64'd0);
    check("arst_ready", 64'(if_a.core_ready_out), 64'd1);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 64'(if_a.core_ready_out), 64'd1);
    check("post_rst_busy", 64'(if_a.busy_out), 64'd0);
    dv0 = dv_cnt_a; done0 = done_cnt_a;
    load_ab();
    check("post_rst_first", 64'(if_a.MP_data_out), 64'h6A);
    serve_ab(0, 31);
    finish_frame_ab(dv0, done0, 32);

    // Test 6: 64-bit words, 4 per frame, 16-bit chunks
    dv0 = dv_cnt_c; done0 = done_cnt_c;
    for (int i = 0; i < 4; i++) begin
      check("c_ready_load", 64'(if_c.core_ready_out), 64'd1);
      c_valid = 1'b1;
      c_word  = c_words[i];
      step();
    end
    c_valid = 1'b0;
    check("c_latency_dv", 64'(if_c.MP_dv_out), 64'd1);
    for (int c = 0; c < 16; c++) begin
      t = 0;
      while (!if_c.MP_dv_out && t < 64) begin
        step();
        t++;
      end
      check("c_dv_seen", 64'(if_c.MP_dv_out), 64'd1);
      check("c_chunk", 64'(if_c.MP_data_out), 64'(exp_c[c]));
      step();
      step();
      c_done = 1'b1;
      step();
      c_done = 1'b0;
    end
    check("c_frame_done", 64'(if_c.frame_done_out), 64'd1);
    step();
    check("c_idle_busy", 64'(if_c.busy_out), 64'd0);
    check("c_dv_count", 64'(dv_cnt_c - dv0), 64'd16);
    check("c_done_count", 64'(done_cnt_c - done0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
